// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, iterative shift-add multiplier and the EX/MEM register.
// A MUL holds the front of the pipe via stall until its final partial product is accumulated.
module ex_stage #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      reg_write_in,
  input  logic                      branch_in,
  input  logic                      mem_read_in,
  input  logic                      mem_to_reg_in,
  input  logic                      mem_write_in,
  input  logic [3:0]                ALU_op,
  input  logic                      ALU_src,
  input  logic [DATA_WIDTH-1:0]     read_data1,
  input  logic [DATA_WIDTH-1:0]     read_data2,
  input  logic [DATA_WIDTH-1:0]     immediate,
  input  logic [1:0]                forward_a,
  input  logic [1:0]                forward_b,
  input  logic [DATA_WIDTH-1:0]     forward_mem_data,
  input  logic [DATA_WIDTH-1:0]     forward_wb_data,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  output logic                      reg_write_out,
  output logic                      branch_out,
  output logic                      mem_read_out,
  output logic                      mem_to_reg_out,
  output logic                      mem_write_out,
  output logic                      zero,
  output logic [DATA_WIDTH-1:0]     ALU_result_out,
  output logic [DATA_WIDTH-1:0]     write_data_out,
  output logic [REG_ADDR_WIDTH-1:0] write_register_out,
  output logic                      stall
);

  localparam int unsigned SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [SHW-1:0]        r_cnt;

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_bf;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_pp;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_is_mul;
  logic                  w_last;
  logic                  w_load;

  // 10 selects MEM bypass, 01 selects WB bypass, 00/11 select the register file value
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] reg_v,
    input logic [DATA_WIDTH-1:0] mem_v,
    input logic [DATA_WIDTH-1:0] wb_v
  );
    logic [DATA_WIDTH-1:0] v;
    case (sel)
      2'b10:   v = mem_v;
      2'b01:   v = wb_v;
      default: v = reg_v;
    endcase
    return v;
  endfunction

  assign w_a  = fwd_sel(forward_a, read_data1, forward_mem_data, forward_wb_data);
  assign w_bf = fwd_sel(forward_b, read_data2, forward_mem_data, forward_wb_data);
  assign w_b  = ALU_src ? immediate : w_bf;

  // Single-cycle ALU; MUL is handled by the iterative datapath below
  always_comb begin
    w_alu = '0;
    case (ALU_op)
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_ADD:  w_alu = w_a + w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLL:  w_alu = w_a << w_b[SHW-1:0];
      OP_SRL:  w_alu = w_a >> w_b[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  assign w_pp       = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
  assign w_acc_next = r_acc + w_pp;
  assign w_is_mul   = (ALU_op == OP_MUL);
  assign w_last     = (r_cnt == SHW'(DATA_WIDTH - 1));
  assign w_result   = (r_state == S_BUSY) ? w_acc_next : w_alu;

  // EX/MEM takes a real instruction only for a non-MUL in IDLE or the final multiply cycle
  assign w_load = !flush && (((r_state == S_IDLE) && !w_is_mul) ||
                             ((r_state == S_BUSY) && w_last));

  assign stall = !reset && !flush && (((r_state == S_IDLE) && w_is_mul) ||
                                      ((r_state == S_BUSY) && !w_last));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_mcand            <= '0;
      r_mplier           <= '0;
      r_acc              <= '0;
      r_cnt              <= '0;
      reg_write_out      <= 1'b0;
      branch_out         <= 1'b0;
      mem_read_out       <= 1'b0;
      mem_to_reg_out     <= 1'b0;
      mem_write_out      <= 1'b0;
      zero               <= 1'b0;
      ALU_result_out     <= '0;
      write_data_out     <= '0;
      write_register_out <= '0;
    end else begin
      if (w_load) begin
        reg_write_out      <= reg_write_in;
        branch_out         <= branch_in;
        mem_read_out       <= mem_read_in;
        mem_to_reg_out     <= mem_to_reg_in;
        mem_write_out      <= mem_write_in;
        zero               <= (w_result == '0);
        ALU_result_out     <= w_result;
        write_data_out     <= w_bf;
        write_register_out <= write_register_in;
      end else begin
        reg_write_out      <= 1'b0;
        branch_out         <= 1'b0;
        mem_read_out       <= 1'b0;
        mem_to_reg_out     <= 1'b0;
        mem_write_out      <= 1'b0;
        zero               <= 1'b0;
        ALU_result_out     <= '0;
        write_data_out     <= '0;
        write_register_out <= '0;
      end

      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_mul) begin
              r_mcand  <= w_a;
              r_mplier <= w_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_BUSY;
            end
          end
          S_BUSY: begin
            r_acc <= w_acc_next;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + SHW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a cycle-level reference model compared every cycle, plus directed
// vectors with literal expectations that pin the model.
module tb_ex_stage;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [3:0]    ALU_op;
  logic          ALU_src;
  logic [DW-1:0] read_data1, read_data2, immediate;
  logic [1:0]    forward_a, forward_b;
  logic [DW-1:0] forward_mem_data, forward_wb_data;
  logic [RW-1:0] write_register_in;
  logic          reg_write_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out;
  logic          zero;
  logic [DW-1:0] ALU_result_out, write_data_out;
  logic [RW-1:0] write_register_out;
  logic          stall;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .reg_write_in(reg_write_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .ALU_op(ALU_op), .ALU_src(ALU_src),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .forward_a(forward_a), .forward_b(forward_b),
    .forward_mem_data(forward_mem_data), .forward_wb_data(forward_wb_data),
    .write_register_in(write_register_in),
    .reg_write_out(reg_write_out), .branch_out(branch_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .zero(zero), .ALU_result_out(ALU_result_out), .write_data_out(write_data_out),
    .write_register_out(write_register_out), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]    ctl;   // reg_write, branch, mem_read, mem_to_reg, mem_write
    logic          zero;
    logic [DW-1:0] res;
    logic [DW-1:0] wd;
    logic [RW-1:0] wr;
  } exm_t;

  exm_t          m_exp;
  bit            m_busy = 1'b0;
  int            m_left = 0;
  logic [DW-1:0] m_prod;
  logic [DW-1:0] m_a, m_bf, m_b;
  logic          m_stall;

  function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] r,
                                        input logic [DW-1:0] m, input logic [DW-1:0] w);
    if (sel == 2'b10) return m;
    if (sel == 2'b01) return w;
    return r;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int ia, ib, sa, sb;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return 8'((ia + ib) % 256);
      OP_SUB:  return 8'((ia - ib + 256) % 256);
      OP_SLT:  return (sa < sb) ? 8'd1 : 8'd0;
      OP_SLL:  return 8'((ia * (2 ** (ib % 8))) % 256);
      OP_SRL:  return 8'(ia / (2 ** (ib % 8)));
      default: return 8'd0;
    endcase
  endfunction

  function automatic exm_t mk(input logic [DW-1:0] r, input logic [DW-1:0] wd);
    exm_t e;
    e.ctl  = {reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in};
    e.zero = (r == 8'd0);
    e.res  = r;
    e.wd   = wd;
    e.wr   = write_register_in;
    return e;
  endfunction

  // Compare on the falling edge, then advance the model for the coming rising edge
  always @(negedge clock) begin
    if (reset) begin
      m_exp  = '0;
      m_busy = 1'b0;
      m_left = 0;
    end
    check("reg_write_out",      reg_write_out,      m_exp.ctl[4]);
    check("branch_out",         branch_out,         m_exp.ctl[3]);
    check("mem_read_out",       mem_read_out,       m_exp.ctl[2]);
    check("mem_to_reg_out",     mem_to_reg_out,     m_exp.ctl[1]);
    check("mem_write_out",      mem_write_out,      m_exp.ctl[0]);
    check("zero",               zero,               m_exp.zero);
    check("ALU_result_out",     ALU_result_out,     m_exp.res);
    check("write_data_out",     write_data_out,     m_exp.wd);
    check("write_register_out", write_register_out, m_exp.wr);
    m_stall = !reset && !flush && ((!m_busy && ALU_op == OP_MUL) || (m_busy && m_left > 1));
    check("stall", stall, m_stall);
    if (!reset) begin
      m_a  = fwd(forward_a, read_data1, forward_mem_data, forward_wb_data);
      m_bf = fwd(forward_b, read_data2, forward_mem_data, forward_wb_data);
      m_b  = ALU_src ? immediate : m_bf;
      if (flush) begin
        m_exp  = '0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_exp  = mk(m_prod, m_bf);
          m_busy = 1'b0;
        end else begin
          m_exp = '0;
        end
        m_left--;
      end else if (ALU_op == OP_MUL) begin
        m_busy = 1'b1;
        m_left = DW;
        m_prod = 8'((int'(m_a) * int'(m_b)) % 256);
        m_exp  = '0;
      end else begin
        m_exp = mk(alu_ref(ALU_op, m_a, m_b), m_bf);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic [4:0] ctl, input logic [RW-1:0] wr);
    ALU_op            = op;
    read_data1        = r1;
    read_data2        = r2;
    {reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in} = ctl;
    write_register_in = wr;
    forward_a         = 2'b00;
    forward_b         = 2'b00;
    forward_mem_data  = '0;
    forward_wb_data   = '0;
    ALU_src           = 1'b0;
    immediate         = '0;
  endtask

  task automatic mul_seq(input string tag, input logic [DW-1:0] exp_res, input bit chg);
    for (int k = 1; k <= 8; k++) begin
      #1 check({tag, "_stall_hi"}, stall, 1);
      tick();
      check({tag, "_bubble_rw"}, reg_write_out, 0);
      check({tag, "_bubble_res"}, ALU_result_out, 0);
      if (chg && k == 3) read_data1 = 8'h77;
    end
    #1 check({tag, "_stall_lo"}, stall, 0);
    tick();
    check({tag, "_res"}, ALU_result_out, exp_res);
    check({tag, "_zero"}, zero, (exp_res == 8'h00));
    check({tag, "_rw"}, reg_write_out, 1);
  endtask

  logic [3:0]    v_op  [11] = '{OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLT, OP_SLL, OP_SRL,
                                OP_ADD, 4'b1001, OP_SUB, OP_ADD};
  logic [DW-1:0] v_r1  [11] = '{8'hF0, 8'hF0, 8'hAA, 8'h80, 8'h01, 8'h81, 8'h81,
                                8'hFF, 8'h12, 8'h05, 8'h10};
  logic [DW-1:0] v_r2  [11] = '{8'h3C, 8'h0C, 8'hFF, 8'h01, 8'h80, 8'h0B, 8'h0F,
                                8'h01, 8'h34, 8'h07, 8'h99};
  logic          v_src [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [DW-1:0] v_exp [11] = '{8'h30, 8'hFC, 8'h55, 8'h01, 8'h00, 8'h08, 8'h01,
                                8'h00, 8'h00, 8'hFE, 8'h32};

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    instr(OP_AND, 8'h00, 8'h00, 5'b00000, 5'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // ADD with MEM bypass on B
    instr(OP_ADD, 8'h05, 8'h33, 5'b10010, 5'd7);
    forward_b        = 2'b10;
    forward_mem_data = 8'hFE;
    tick();
    check("add_res", ALU_result_out, 8'h03);
    check("add_zero", zero, 0);
    check("add_rw", reg_write_out, 1);
    check("add_m2r", mem_to_reg_out, 1);
    check("add_wd", write_data_out, 8'hFE);
    check("add_wr", write_register_out, 7);

    // SUB equal for beq
    instr(OP_SUB, 8'h3C, 8'h3C, 5'b01000, 5'd0);
    tick();
    check("sub_res", ALU_result_out, 8'h00);
    check("sub_zero", zero, 1);
    check("sub_branch", branch_out, 1);

    // Store path: WB bypass on B, immediate address offset
    instr(OP_ADD, 8'h20, 8'h00, 5'b00001, 5'd0);
    forward_b       = 2'b01;
    forward_wb_data = 8'hA5;
    ALU_src         = 1'b1;
    immediate       = 8'h10;
    tick();
    check("st_res", ALU_result_out, 8'h30);
    check("st_wd", write_data_out, 8'hA5);
    check("st_mw", mem_write_out, 1);

    // Directed ALU vectors
    for (int i = 0; i < 11; i++) begin
      instr(v_op[i], v_r1[i], v_r2[i], 5'b10000, RW'(i));
      ALU_src   = v_src[i];
      immediate = 8'h22;
      tick();
      check($sformatf("vec%0d_res", i), ALU_result_out, v_exp[i]);
      check($sformatf("vec%0d_zero", i), zero, (v_exp[i] == 8'h00));
    end

    // forward select 11 behaves as register
    instr(OP_OR, 8'h01, 8'h02, 5'b10000, 5'd9);
    forward_a        = 2'b11;
    forward_mem_data = 8'h40;
    forward_wb_data  = 8'h80;
    tick();
    check("fwd11_res", ALU_result_out, 8'h03);

    // Multiply; A changed mid-run must not matter, then back-to-back MUL wrapping to zero
    instr(OP_MUL, 8'h0D, 8'h0B, 5'b10000, 5'd3);
    mul_seq("mul1", 8'h8F, 1'b1);
    check("mul1_wr", write_register_out, 3);
    check("mul1_wd", write_data_out, 8'h0B);
    instr(OP_MUL, 8'h10, 8'h10, 5'b10000, 5'd4);
    mul_seq("mul2", 8'h00, 1'b0);

    // Flush at BUSY counter=3
    instr(OP_MUL, 8'h03, 8'h05, 5'b10000, 5'd5);
    repeat (4) tick();
    flush = 1'b1;
    #1 check("flush_stall", stall, 0);
    tick();
    check("flush_rw", reg_write_out, 0);
    check("flush_res", ALU_result_out, 0);
    flush = 1'b0;
    instr(OP_ADD, 8'h01, 8'h01, 5'b10000, 5'd6);
    #1 check("postflush_stall", stall, 0);
    tick();
    check("postflush_res", ALU_result_out, 8'h02);

    // Flush in IDLE with a MUL presented: no start
    instr(OP_MUL, 8'h02, 8'h02, 5'b10000, 5'd1);
    flush = 1'b1;
    #1 check("flush_idle_stall", stall, 0);
    tick();
    flush = 1'b0;
    instr(OP_XOR, 8'h0F, 8'h01, 5'b10000, 5'd2);
    tick();
    check("after_idle_flush_res", ALU_result_out, 8'h0E);

    // Asynchronous reset mid-cycle with live outputs
    instr(OP_OR, 8'h5A, 8'h00, 5'b11111, 5'd31);
    tick();
    #1 reset = 1'b1;
    #1;
    check("rst_res", ALU_result_out, 0);
    check("rst_rw", reg_write_out, 0);
    check("rst_wr", write_register_out, 0);
    check("rst_stall", stall, 0);
    tick();
    reset = 1'b0;

    // Reset in the middle of a multiply
    instr(OP_MUL, 8'h07, 8'h09, 5'b10000, 5'd8);
    repeat (3) tick();
    #1 reset = 1'b1;
    #1 check("rst_mul_stall", stall, 0);
    tick();
    reset = 1'b0;
    instr(OP_ADD, 8'h40, 8'h02, 5'b10000, 5'd8);
    tick();
    check("rst_mul_add_res", ALU_result_out, 8'h42);

    instr(OP_AND, 8'h00, 8'h00, 5'b00000, 5'd0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
